uart_rx_fifo: RTL
=================

Name: uart_rx_fifo

Overview:
Serial receive front-end between the board RX pin and the microcomputer's serial interface. It synchronises and 16x-oversamples the asynchronous 8N1 line, and buffers received bytes in a show-ahead FIFO. It drives the RTS flow-control pin with hysteresis so the host pauses before the buffer overflows. Framing and overrun errors are reported as sticky flags.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s
DEPTH, 16, FIFO entries; must be a power of 2, at least 4
HI_WATER, 12, count at or above which rts_n deasserts (goes 1)
LO_WATER, 4, count at or below which rts_n reasserts (goes 0); must be less than HI_WATER

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rxd  in  1  asynchronous serial input, idle high
rd_en  in  1  pop the head entry; ignored when empty
rd_data  out  8  head entry, valid while rd_valid=1
rd_valid  out  1  FIFO not empty
count  out  $clog2(DEPTH)+1  current FIFO occupancy
rts_n  out  1  0 = peer may send, 1 = peer must pause
frame_err  out  1  sticky: stop bit sampled low
overrun  out  1  sticky: byte arrived while FIFO full
clr_err  in  1  one-cycle pulse clearing both sticky flags

Behaviour:
- Reset is synchronous and active-low (rst_n) on clock clk.
- Reset values:
  - FIFO is empty: count=0, rd_valid=0, rd_data=0.
  - frame_err=0, overrun=0, rts_n=1.
  - Both rxd synchroniser flops reset to 1.
  - FSM resets to WAIT_IDLE.
- rts_n is registered: it falls to 0 on the first cycle after rst_n goes high.
- Synchroniser: two flops; rxd_s is the second flop output. The FSM uses only rxd_s.
- Oversample tick:
  - DIV = (CLK_HZ + 8*BAUD) / (16*BAUD), computed at elaboration; DIV is at least 1.
  - tick pulses every DIV cycles.
  - The divider and the 4-bit sample counter clear on every transition out of IDLE, so phase is aligned to the start edge.
- FSM states:
  - WAIT_IDLE: go to IDLE on the first cycle with rxd_s=1. Prevents a low line at reset release, or after a break, from being taken as a start bit.
  - IDLE: rxd_s=0 goes to START.
  - START: on the 8th tick (mid-bit), rxd_s=1 means a glitch: go to IDLE with no byte and no error. Otherwise go to DATA.
  - DATA: sample at each 16th tick thereafter, LSB first, into an 8-bit shift register. After bit 7 go to STOP.
  - STOP: sample 16 ticks after bit 7.
    - rxd_s=1: push the byte, go to IDLE.
    - rxd_s=0: set frame_err, discard the byte, go to WAIT_IDLE.
- Timing: the stop sample is at tick 8+16*9=152 after entering START. The push is visible (rd_valid/count) on the following cycle.
- FIFO is show-ahead: rd_data presents the head combinationally from the registered read pointer.
- FIFO pointer and count rules:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - count has one extra bit so that count=DEPTH means full.
  - Push and pop in the same cycle: both take effect, count is unchanged. This includes the full case, because the pop frees the slot.
  - Push while full without a pop: byte dropped, overrun set, FIFO unchanged.
  - Pop while empty: no effect.
- RTS hysteresis, from next-state count:
  - next count >= HI_WATER: rts_n becomes 1.
  - next count <= LO_WATER: rts_n becomes 0.
  - Otherwise rts_n holds.
- Sticky flags: clr_err clears both flags. If a set event and clr_err occur in the same cycle, set wins.
- Reset mid-frame: the partial byte is lost and there is no error. Reception re-arms only after the line is seen high.

Decomposition:
- Package uart_pkg holds:
  - the rx_state_t enum (WAIT_IDLE, IDLE, START, DATA, STOP);
  - a constant function baud_div(clk_hz, baud);
  - the DATA_W=8 constant.
- One sub-module, sync_fifo (parameters DEPTH and WIDTH), provides the storage, pointers and count. Top-level logic keeps the synchroniser, tick, FSM, error flags and RTS.

Test Plan:
All scenarios use CLK_HZ=1_843_200, BAUD=115200, so DIV=1 and one bit lasts 16 cycles.
1. Drive an 8N1 frame of 0x55 -> rd_valid=1, rd_data=0x55, count=1 on the cycle after the stop-bit sample. No flags. Pulse rd_en -> rd_valid=0.
2. Pulse rxd low for 4 cycles -> no push, frame_err=0, FSM back in IDLE; then a valid frame of 0x7E -> received correctly.
3. Send 0xA3 with stop bit 0, then hold the line low 100 cycles -> frame_err=1, count=0. Raise the line, send 0x3C -> rd_data=0x3C. Pulse clr_err -> frame_err=0.
4. Send 12 bytes with no reads -> rts_n goes 1 as count reaches 12. Pop 8 -> rts_n goes 0 as count reaches 4, and stays 0 at count 5..11.
5. Send 17 bytes with no reads -> count=16, overrun=1, 17th byte dropped; first pop returns byte 1. Push and pop in the same cycle while full -> count stays 16, new byte accepted.
6. Assert rst_n mid-frame with rxd low, release it while rxd is still low -> no start detected. Line goes high, then a frame of 0x81 -> received correctly, count=1.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
// uart_pkg: shared receiver state encoding, data width and baud divider helper
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} rx_state_t;

    function automatic int baud_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + 8 * baud) / (16 * baud);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: show-ahead FIFO with wrapping pointers and an occupancy count one bit wider than the pointers
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   count_nxt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign rd_valid  = count != '0;
    assign full      = count == FULL;
    assign do_rd     = rd_en && rd_valid;
    assign do_wr     = wr_en && (!full || do_rd);
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
    assign count_nxt = (do_wr && !do_rd) ? count + 1'b1 :
                       (do_rd && !do_wr) ? count - 1'b1 : count;

    // storage is not reset; rd_data is masked while empty
    always_ff @(posedge clk)
        if (do_wr) mem[wr_ptr] <= wr_data;

    // pointers and occupancy
    always_ff @(posedge clk)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
        end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled 8N1 receiver feeding a show-ahead FIFO, with RTS hysteresis and sticky errors
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ   = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16,
    parameter int HI_WATER = 12,
    parameter int LO_WATER = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rxd,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] count,
    output logic                   rts_n,
    output logic                   frame_err,
    output logic                   overrun,
    input  logic                   clr_err
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] HI = CW'(HI_WATER);
    localparam logic [CW-1:0] LO = CW'(LO_WATER);

    rx_state_t         state, state_nxt;
    logic              s1, rxd_s;
    logic [1:0]        warm;
    logic [DCW-1:0]    div_cnt;
    logic [3:0]        sc;
    logic [2:0]        bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic              active, tick, samp, push, fe_set, ovr_set, full;
    logic [CW-1:0]     count_nxt;

    assign active  = state inside {START, DATA, STOP};
    assign tick    = active && (div_cnt == DCW'(DIV - 1));
    assign samp    = tick && (sc == 4'd7);
    assign push    = (state == STOP) && samp && rxd_s;
    assign fe_set  = (state == STOP) && samp && !rxd_s;
    assign ovr_set = push && full && !rd_en;

    // two-flop synchroniser; warm delays WAIT_IDLE until rxd_s reflects the real line, not the reset value
    always_ff @(posedge clk)
        if (!rst_n) begin
            s1    <= 1'b1;
            rxd_s <= 1'b1;
            warm  <= '0;
        end else begin
            s1    <= rxd;
            rxd_s <= s1;
            warm  <= {warm[0], 1'b1};
        end

    // divider and tick counter idle at zero outside a frame so sampling phase follows the start edge
    always_ff @(posedge clk)
        if (!rst_n || !active) begin
            div_cnt <= '0;
            sc      <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            sc      <= tick ? sc + 1'b1 : sc;
        end

    // receiver state register
    always_ff @(posedge clk)
        if (!rst_n) state <= WAIT_IDLE;
        else        state <= state_nxt;

    // next state: every decision is taken at the mid-bit sample
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_IDLE: if (rxd_s && warm[1])        state_nxt = IDLE;
            IDLE:      if (!rxd_s)                  state_nxt = START;
            START:     if (samp)                    state_nxt = rxd_s ? IDLE : DATA;
            DATA:      if (samp && bit_cnt == 3'd7) state_nxt = STOP;
            STOP:      if (samp)                    state_nxt = rxd_s ? IDLE : WAIT_IDLE;
            default:                                state_nxt = WAIT_IDLE;
        endcase
    end

    // LSB-first shift register and bit counter
    always_ff @(posedge clk)
        if (!rst_n) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (state == START) begin
            bit_cnt <= '0;
        end else if (state == DATA && samp) begin
            shreg   <= {rxd_s, shreg[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
        end

    // sticky errors (set beats clear) and RTS hysteresis on the next occupancy
    always_ff @(posedge clk)
        if (!rst_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            rts_n     <= 1'b1;
        end else begin
            frame_err <= fe_set | (frame_err & ~clr_err);
            overrun   <= ovr_set | (overrun & ~clr_err);
            rts_n     <= (count_nxt >= HI) ? 1'b1 : (count_nxt <= LO) ? 1'b0 : rts_n;
        end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (push),
        .wr_data   (shreg),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .full      (full),
        .count     (count),
        .count_nxt (count_nxt)
    );

endmodule
